// File: rtl/timer_counter_if.sv
// Device-slot bus between the address bridge and the timer: word address,
// write data and write enable in; read data and interrupt request out.
interface timer_counter_if;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        IRQ;

   modport master (
      output Addr,
      output WE,
      output WD,
      input  RD,
      input  IRQ
   );

   modport slave (
      input  Addr,
      input  WE,
      input  WD,
      output RD,
      output IRQ
   );
endinterface

// File: rtl/timer_counter.sv
// Register-mapped 32-bit down-counting timer (IDLE/LOAD/CNT/INT) with a
// level interrupt request, one-shot or periodic.
module timer_counter (
   input  logic            clk,
   input  logic            reset_n,
   timer_counter_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   logic [3:0]  ctrl_q,     ctrl_d;
   logic [31:0] preset_q,   preset_d;
   logic [31:0] count_q,    count_d;
   logic        irq_flag_q, irq_flag_d;
   logic [1:0]  state_q,    state_d;

   logic        en;
   logic        periodic;
   logic        expire;
   logic [1:0]  offset;
   logic        unused_addr_bits;

   assign en       = ctrl_q[0];
   assign periodic = (ctrl_q[2:1] == 2'd1);
   assign offset   = bus.Addr[3:2];
   assign expire   = (state_q == ST_CNT) && en && (count_q <= 32'd1);
   assign unused_addr_bits = ^bus.Addr[31:4];

   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      state_d    = state_q;

      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = en ? ST_CNT : ST_IDLE;
         end
         ST_CNT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               state_d = ST_INT;
            end
         end
         default: begin
            if (periodic) begin
               irq_flag_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = ST_IDLE;
            end
         end
      endcase

      // CPU writes are applied after the FSM so a CTRL write overrides the one-shot EN clear.
      if (bus.WE) begin
         case (offset)
            2'd0: begin
               ctrl_d     = bus.WD[3:0];
               irq_flag_d = 1'b0;
            end
            2'd1: preset_d = bus.WD;
            default: ;
         endcase
      end

      // Expiry outranks the flag clear of a simultaneous CTRL write.
      if (expire) irq_flag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q     <= 4'd0;
         preset_q   <= 32'd0;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
         state_q    <= ST_IDLE;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
         state_q    <= state_d;
      end
   end

   always_comb begin
      case (offset)
         2'd0:    bus.RD = {28'd0, ctrl_q};
         2'd1:    bus.RD = preset_q;
         2'd2:    bus.RD = count_q;
         default: bus.RD = 32'd0;
      endcase
   end

   assign bus.IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed testbench for timer_counter: hand-computed expectations per scenario.
module tb_timer_counter;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_err;

   timer_counter_if bus ();

   timer_counter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
      bus.Addr = {28'd0, off};
      bus.WD   = data;
      bus.WE   = 1'b1;
      @(posedge clk);
      #1;
      bus.WE   = 1'b0;
      bus.WD   = 32'd0;
   endtask

   task automatic rd(input logic [1:0] off, output logic [31:0] data);
      bus.Addr = {28'd0, off};
      #1;
      data = bus.RD;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      step(1);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'h20);
      bus_write(2'd0, 32'h9);
      step(18);
      rd(2'd2, v);
      if (v !== 32'h10) begin $display("FAIL reset_precount: got %h expected %h", v, 32'h10); n_err++; end
      n_vec++;
      #1;
      reset_n = 1'b0;
      #1;
      if (bus.IRQ !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", bus.IRQ); n_err++; end
      n_vec++;
      for (int i = 0; i < 4; i++) begin
         rd(i[1:0], v);
         if (v !== 32'd0) begin $display("FAIL reset_rd%0d: got %h expected 0", i, v); n_err++; end
         n_vec++;
      end
      reset_n = 1'b1;
      step(1);
      rd(2'd2, v);
      if (v !== 32'd0) begin $display("FAIL reset_count_after: got %h expected 0", v); n_err++; end
      n_vec++;
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd5);
      bus_write(2'd0, 32'h9);
      step(6);
      if (bus.IRQ !== 1'b0) begin $display("FAIL oneshot_irq_e6: got %b expected 0", bus.IRQ); n_err++; end
      n_vec++;
      step(1);
      if (bus.IRQ !== 1'b1) begin $display("FAIL oneshot_irq_e7: got %b expected 1", bus.IRQ); n_err++; end
      n_vec++;
      rd(2'd2, v);
      if (v !== 32'd0) begin $display("FAIL oneshot_count_e7: got %h expected 0", v); n_err++; end
      n_vec++;
      step(1);
      rd(2'd0, v);
      if (v !== 32'h8) begin $display("FAIL oneshot_ctrl_e8: got %h expected 8", v); n_err++; end
      n_vec++;
      step(3);
      if (bus.IRQ !== 1'b1) begin $display("FAIL oneshot_irq_hold: got %b expected 1", bus.IRQ); n_err++; end
      n_vec++;
      bus_write(2'd0, 32'h0);
      if (bus.IRQ !== 1'b0) begin $display("FAIL oneshot_irq_clear: got %b expected 0", bus.IRQ); n_err++; end
      n_vec++;
   endtask

   task automatic test_periodic();
      logic [31:0] v;
      logic [31:0] exp_cnt;
      logic        exp_irq;
      int          tbl [5] = '{3, 2, 1, 0, 0};
      do_reset();
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'hB);
      for (int e = 1; e <= 16; e++) begin
         step(1);
         exp_irq = (e == 5) || (e == 10) || (e == 15);
         exp_cnt = (e == 1) ? 32'd0 : 32'(tbl[(e - 2) % 5]);
         if (bus.IRQ !== exp_irq) begin $display("FAIL periodic_irq_e%0d: got %b expected %b", e, bus.IRQ, exp_irq); n_err++; end
         n_vec++;
         rd(2'd2, v);
         if (v !== exp_cnt) begin $display("FAIL periodic_count_e%0d: got %h expected %h", e, v, exp_cnt); n_err++; end
         n_vec++;
      end
   endtask

   task automatic test_masked();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'h1);
      for (int e = 1; e <= 5; e++) begin
         step(1);
         if (bus.IRQ !== 1'b0) begin $display("FAIL masked_irq_e%0d: got %b expected 0", e, bus.IRQ); n_err++; end
         n_vec++;
         if (e == 4) begin
            rd(2'd2, v);
            if (v !== 32'd0) begin $display("FAIL masked_count_e4: got %h expected 0", v); n_err++; end
            n_vec++;
         end
      end
      rd(2'd0, v);
      if (v !== 32'h0) begin $display("FAIL masked_ctrl_e5: got %h expected 0", v); n_err++; end
      n_vec++;
   endtask

   task automatic test_pause();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd10);
      bus_write(2'd0, 32'h1);
      step(5);
      bus_write(2'd0, 32'h0);
      rd(2'd2, v);
      if (v !== 32'd6) begin $display("FAIL pause_count: got %h expected 6", v); n_err++; end
      n_vec++;
      step(3);
      rd(2'd2, v);
      if (v !== 32'd6) begin $display("FAIL pause_hold: got %h expected 6", v); n_err++; end
      n_vec++;
      bus_write(2'd0, 32'h1);
      step(1);
      rd(2'd2, v);
      if (v !== 32'd6) begin $display("FAIL restart_r1: got %h expected 6", v); n_err++; end
      n_vec++;
      step(1);
      rd(2'd2, v);
      if (v !== 32'd10) begin $display("FAIL restart_r2: got %h expected a", v); n_err++; end
      n_vec++;
   endtask

   task automatic test_preset_during_cnt();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd4);
      bus_write(2'd0, 32'h1);
      step(2);
      bus_write(2'd1, 32'd7);
      rd(2'd2, v);
      if (v !== 32'd3) begin $display("FAIL preset_in_cnt: got %h expected 3", v); n_err++; end
      n_vec++;
      rd(2'd1, v);
      if (v !== 32'd7) begin $display("FAIL preset_readback: got %h expected 7", v); n_err++; end
      n_vec++;
   endtask

   task automatic test_edge();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'h9);
      step(2);
      if (bus.IRQ !== 1'b0) begin $display("FAIL edge_irq_e2: got %b expected 0", bus.IRQ); n_err++; end
      n_vec++;
      step(1);
      if (bus.IRQ !== 1'b1) begin $display("FAIL edge_irq_e3: got %b expected 1", bus.IRQ); n_err++; end
      n_vec++;
      bus_write(2'd2, 32'hFFFF_FFFF);
      bus_write(2'd3, 32'h0000_1234);
      rd(2'd2, v);
      if (v !== 32'd0) begin $display("FAIL edge_count_ro: got %h expected 0", v); n_err++; end
      n_vec++;
      rd(2'd3, v);
      if (v !== 32'd0) begin $display("FAIL edge_off3: got %h expected 0", v); n_err++; end
      n_vec++;
      rd(2'd0, v);
      if (v !== 32'h8) begin $display("FAIL edge_ctrl: got %h expected 8", v); n_err++; end
      n_vec++;
      if (bus.IRQ !== 1'b1) begin $display("FAIL edge_irq_kept: got %b expected 1", bus.IRQ); n_err++; end
      n_vec++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      do_reset();
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'h9);
      step(3);
      bus_write(2'd0, 32'h9);
      if (bus.IRQ !== 1'b1) begin $display("FAIL b2b_irq_wins: got %b expected 1", bus.IRQ); n_err++; end
      n_vec++;
      bus_write(2'd0, 32'h9);
      rd(2'd0, v);
      if (v !== 32'h9) begin $display("FAIL b2b_ctrl_wins: got %h expected 9", v); n_err++; end
      n_vec++;
      if (bus.IRQ !== 1'b0) begin $display("FAIL b2b_irq_cleared: got %b expected 0", bus.IRQ); n_err++; end
      n_vec++;
      step(2);
      rd(2'd2, v);
      if (v !== 32'd2) begin $display("FAIL b2b_reload: got %h expected 2", v); n_err++; end
      n_vec++;
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      reset_n  = 1'b0;
      bus.Addr = '0;
      bus.WE   = 1'b0;
      bus.WD   = 32'd0;
      #12;
      reset_n  = 1'b1;
      test_reset();
      test_oneshot();
      test_periodic();
      test_masked();
      test_pause();
      test_preset_during_cnt();
      test_edge();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
